dlx_fetch_unit: RTL

Instruction-fetch front end of the DLX 5-stage pipeline, directly upstream of decode. Issues in-order instruction-memory reads through a req/gnt + rvalid handshake. Buffers returned words with their PC+4 in a small prefetch FIFO and presents one instruction per cycle to the ID stage. Handles decode stalls and taken-branch/jump redirects, discarding wrong-path fetches and emitting NOP `32'h00000015` when it has no valid word.

---
 rtl/dlx_pkg.sv | 18 +
 rtl/dlx_fetch_unit_if.sv | 15 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/dlx_fetch_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions used by the fetch front end: architectural NOP,
// datapath width, PC step and the prefetch entry layout.
package dlx_pkg;

  localparam int          DLX_XLEN    = 32;
  localparam logic [31:0] DLX_NOP     = 32'h00000015;
  localparam logic [31:0] DLX_PC_STEP = 32'd4;

  typedef struct packed {
    logic [DLX_XLEN-1:0] inst;
    logic [DLX_XLEN-1:0] pc4;
  } fetch_entry_t;

  function automatic logic [DLX_XLEN-1:0] align_pc(input logic [DLX_XLEN-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dlx_fetch_unit_if.sv
// Instruction-memory port. A request is accepted in the cycle where req and gnt
// are both high; rvalid/rdata return accepted requests in order, at least one cycle later.
interface dlx_fetch_unit_if;
  import dlx_pkg::*;

  logic                req;
  logic [DLX_XLEN-1:0] addr;
  logic                gnt;
  logic                rvalid;
  logic [DLX_XLEN-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding {instruction, pc+4}; flush empties it
// in one cycle. Registers update on the falling clock edge like the pipeline.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= next_ptr(r_wr);
      if (i_pop)  r_rd <= next_ptr(r_rd);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch front end: in-order imem requests, prefetch buffering,
// decode-stall hold and branch redirect with wrong-path response discarding.
module dlx_fetch_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = DLX_NOP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dlx_fetch_unit_if.master        imem,
  input  logic                    stall_id,
  input  logic                    branch_id,
  input  logic [DLX_XLEN-1:0]     branch_pc_id,
  output logic [DLX_XLEN-1:0]     inst_id,
  output logic [DLX_XLEN-1:0]     pc_plus_four_id,
  output logic                    valid_id
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic                r_run;
  logic [DLX_XLEN-1:0] r_fetch_pc;
  logic [DLX_XLEN-1:0] r_resp_pc;
  logic [DLX_XLEN-1:0] r_last_pc4;
  logic [CNT_W-1:0]    r_outstanding;
  logic [CNT_W-1:0]    r_discard;

  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_out_next;
  fetch_entry_t        w_head;
  fetch_entry_t        w_push_data;
  logic                w_redirect;
  logic                w_grant;
  logic                w_resp;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;

  assign w_redirect = branch_id && !stall_id;

  // Requests wait one cycle after reset and never overlap a redirect.
  assign imem.req  = r_run && ((r_outstanding + w_count) < DEPTH_C) && !w_redirect;
  assign imem.addr = r_fetch_pc;

  assign w_grant = imem.req && imem.gnt;
  // Responses with nothing outstanding are stale (issued before a reset).
  assign w_resp  = imem.rvalid && (r_outstanding != '0);
  assign w_push  = w_resp && !w_redirect && (r_discard == '0);
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && !stall_id && !w_redirect;

  assign w_push_data = '{inst: imem.rdata, pc4: r_resp_pc + DLX_PC_STEP};

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_grant, w_resp})
      2'b10:   w_out_next = r_outstanding + 1'b1;
      2'b01:   w_out_next = r_outstanding - 1'b1;
      default: ;
    endcase
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_last_pc4    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (w_valid) r_last_pc4 <= w_head.pc4;
      if (w_redirect) begin
        // Everything still in flight after this cycle belongs to the wrong path.
        r_fetch_pc <= align_pc(branch_pc_id);
        r_resp_pc  <= align_pc(branch_pc_id);
        r_discard  <= w_out_next;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + DLX_PC_STEP;
        if (w_resp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
        if (w_push) r_resp_pc <= r_resp_pc + DLX_PC_STEP;
      end
    end
  end

  assign valid_id        = w_valid;
  assign inst_id         = w_valid ? w_head.inst : NOP_INST;
  assign pc_plus_four_id = w_valid ? w_head.pc4  : r_last_pc4;

endmodule
